// File: rtl/tim_arbiter_wires.sv
// Shared types for the TIM refill arbiter: memory request/response
// structs, FSM state encoding and the captured-request record.
package tim_arbiter_wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;

    typedef enum logic [1:0] {
        st_idle   = 2'd0,
        st_busy_i = 2'd1,
        st_busy_d = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        fence;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cap_req_t;

    localparam logic GRANT_IMEM = 1'b0;
    localparam logic GRANT_DMEM = 1'b1;

    function automatic cap_req_t capture_req(input mem_in_type r);
        cap_req_t c;
        c.fence = r.mem_fence;
        c.addr  = r.mem_addr;
        c.wdata = r.mem_wdata;
        c.wstrb = r.mem_wstrb;
        return c;
    endfunction

endpackage

// File: rtl/tim_arbiter_pick.sv
// Combinational grant selection for the TIM arbiter.
// Build option: TIM_ARBITER_RR_EN -- when defined, a tie goes to the side
// opposite last_grant; otherwise dmem always wins a tie.
// grant is one-hot: bit 0 = imem, bit 1 = dmem.
module tim_arbiter_pick
    import tim_arbiter_wires::*;
(
    input  logic       ivalid,
    input  logic       dvalid,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifndef TIM_ARBITER_RR_EN
    // last_grant is still tracked by the top but does not steer selection here.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Resolve a single winner from the two requesters.
    always_comb begin
        grant = 2'b00;
        if (ivalid && dvalid) begin
`ifdef TIM_ARBITER_RR_EN
            grant = (last_grant == GRANT_DMEM) ? 2'b01 : 2'b10;
`else
            grant = 2'b10;
`endif
        end else if (dvalid) begin
            grant = 2'b10;
        end else if (ivalid) begin
            grant = 2'b01;
        end
    end

endmodule

// File: rtl/tim_arbiter.sv
// Arbiter sharing one downstream memory port between the instruction-TIM and
// data-TIM refill engines. One transaction outstanding at a time; the
// downstream request is a one-cycle issue pulse with the captured fields held
// until completion. Build option: TIM_ARBITER_RR_EN (see tim_arbiter_pick).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// st_idle   | no transaction; grant on any requester valid
// st_busy_i | imem transaction outstanding; downstream response to imem
// st_busy_d | dmem transaction outstanding; downstream response to dmem
module tim_arbiter
    import tim_arbiter_wires::*;
(
    input  logic        rst,
    input  logic        clk,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    arb_state_t state;
    logic       last_grant;
    logic       issue;
    cap_req_t   cap;
    logic [1:0] grant;

    // Requesters' own mem_instr is replaced by the granted side.
    logic unused_req_instr;
    assign unused_req_instr = imem_in.mem_instr ^ dmem_in.mem_instr;

    tim_arbiter_pick u_pick (
        .ivalid     (imem_in.mem_valid),
        .dvalid     (dmem_in.mem_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Grant/complete FSM; issue is high only for the first busy cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= st_idle;
            last_grant <= GRANT_IMEM;
            issue      <= 1'b0;
            cap        <= '0;
        end else begin
            case (state)
                st_idle: begin
                    issue <= 1'b0;
                    if (grant[1]) begin
                        state      <= st_busy_d;
                        last_grant <= GRANT_DMEM;
                        issue      <= 1'b1;
                        cap        <= capture_req(dmem_in);
                    end else if (grant[0]) begin
                        state      <= st_busy_i;
                        last_grant <= GRANT_IMEM;
                        issue      <= 1'b1;
                        cap        <= capture_req(imem_in);
                    end
                end
                st_busy_i, st_busy_d: begin
                    issue <= 1'b0;
                    if (mem_out.mem_ready) begin
                        state <= st_idle;
                    end
                end
                default: begin
                    state <= st_idle;
                    issue <= 1'b0;
                end
            endcase
        end
    end

    // Downstream request from registers; response routed only to the owner.
    always_comb begin
        mem_in           = '0;
        mem_in.mem_valid = issue;
        mem_in.mem_fence = cap.fence;
        mem_in.mem_instr = (state == st_busy_i);
        mem_in.mem_addr  = cap.addr;
        mem_in.mem_wdata = cap.wdata;
        mem_in.mem_wstrb = cap.wstrb;
        imem_out         = '0;
        dmem_out         = '0;
        if (state == st_busy_i) begin
            imem_out = mem_out;
        end
        if (state == st_busy_d) begin
            dmem_out = mem_out;
        end
    end

endmodule

// File: tb/tb_tim_arbiter.sv
// Directed bench for tim_arbiter: a table of single-requester transactions
// followed by hand-written contention, mid-transaction and reset sequences.
// Inputs change 1 time unit after a rising edge; outputs sampled on falling edges.
module tb_tim_arbiter;
    import tim_arbiter_wires::*;

    logic        rst;
    logic        clk;
    mem_in_type  imem_in;
    mem_in_type  dmem_in;
    mem_in_type  mem_in;
    mem_out_type imem_out;
    mem_out_type dmem_out;
    mem_out_type mem_out;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        side;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        fence;
        logic        req_instr;
        int          lat;
        logic [31:0] rdata;
        logic        exp_instr;
    } vec_t;

    vec_t tbl[4];
    vec_t vi;
    vec_t vd;
    vec_t vs;

    tim_arbiter dut (
        .rst      (rst),
        .clk      (clk),
        .imem_in  (imem_in),
        .imem_out (imem_out),
        .dmem_in  (dmem_in),
        .dmem_out (dmem_out),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic side, input vec_t v);
        mem_in_type r;
        r.mem_valid = 1'b1;
        r.mem_fence = v.fence;
        r.mem_instr = v.req_instr;
        r.mem_addr  = v.addr;
        r.mem_wdata = v.wdata;
        r.mem_wstrb = v.wstrb;
        if (side) dmem_in = r;
        else      imem_in = r;
    endtask

    // Runs one transaction for v (lat >= 2). Starts and ends just after a rising edge.
    task automatic txn(input string tag, input vec_t v, input int exp_wait,
                       input bit mid_i, input vec_t vmid);
        int waited = 0;
        bit got = 1'b0;
        mem_out_type gs;
        mem_out_type os;
        drive_req(v.side, v);
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (mem_in.mem_valid) got = 1'b1;
            else                  waited++;
        end
        chk({tag, "/issued"}, 64'(got), 64'd1);
        if (!got) return;
        chk({tag, "/wait"},  64'(waited), 64'(exp_wait));
        chk({tag, "/instr"}, 64'(mem_in.mem_instr), 64'(v.exp_instr));
        chk({tag, "/addr"},  64'(mem_in.mem_addr),  64'(v.addr));
        chk({tag, "/wdata"}, 64'(mem_in.mem_wdata), 64'(v.wdata));
        chk({tag, "/wstrb"}, 64'(mem_in.mem_wstrb), 64'(v.wstrb));
        chk({tag, "/fence"}, 64'(mem_in.mem_fence), 64'(v.fence));
        chk({tag, "/rdy0"},  64'({imem_out.mem_ready, dmem_out.mem_ready}), 64'd0);
        for (int c = 2; c <= v.lat; c++) begin
            @(posedge clk);
            #1;
            if (mid_i && c == 2) drive_req(1'b0, vmid);
            if (c == v.lat) begin
                mem_out.mem_ready = 1'b1;
                mem_out.mem_rdata = v.rdata;
            end
            @(negedge clk);
            chk({tag, "/valid_pulse"}, 64'(mem_in.mem_valid), 64'd0);
            chk({tag, "/addr_hold"},   64'(mem_in.mem_addr),  64'(v.addr));
            chk({tag, "/wd_hold"},     64'({mem_in.mem_wdata, mem_in.mem_wstrb, mem_in.mem_fence}),
                                       64'({v.wdata, v.wstrb, v.fence}));
            if (c == v.lat) begin
                gs = v.side ? dmem_out : imem_out;
                os = v.side ? imem_out : dmem_out;
                chk({tag, "/own_ready"},   64'(gs.mem_ready), 64'd1);
                chk({tag, "/own_rdata"},   64'(gs.mem_rdata), 64'(v.rdata));
                chk({tag, "/other_ready"}, 64'(os.mem_ready), 64'd0);
                chk({tag, "/other_rdata"}, 64'(os.mem_rdata), 64'd0);
            end else begin
                chk({tag, "/early_rdy"}, 64'({imem_out.mem_ready, dmem_out.mem_ready}), 64'd0);
            end
        end
        @(posedge clk);
        #1;
        mem_out = '0;
        if (v.side) dmem_in.mem_valid = 1'b0;
        else        imem_in.mem_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "/addr"},  64'(mem_in.mem_addr), 64'd0);
        chk({tag, "/wdata"}, 64'(mem_in.mem_wdata), 64'd0);
        chk({tag, "/ctl"},   64'({mem_in.mem_valid, mem_in.mem_fence, mem_in.mem_instr, mem_in.mem_wstrb}), 64'd0);
        chk({tag, "/iout"},  64'(imem_out), 64'd0);
        chk({tag, "/dout"},  64'(dmem_out), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        imem_in = '0;
        dmem_in = '0;
        mem_out = '0;
        @(negedge clk);
        check_reset_vals(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        vec_t exp_seq[4];
        bit   got;
        rst     = 1'b0;
        imem_in = '0;
        dmem_in = '0;
        mem_out = '0;

        tbl[0] = '{side:1'b0, addr:32'h0000_1000, wdata:32'h0, wstrb:4'h0, fence:1'b0,
                   req_instr:1'b1, lat:3, rdata:32'hDEAD_BEEF, exp_instr:1'b1};
        tbl[1] = '{side:1'b1, addr:32'h2000_0040, wdata:32'h0, wstrb:4'h0, fence:1'b0,
                   req_instr:1'b1, lat:2, rdata:32'hCAFE_F00D, exp_instr:1'b0};
        tbl[2] = '{side:1'b0, addr:32'h0000_1FFC, wdata:32'h0, wstrb:4'h0, fence:1'b1,
                   req_instr:1'b0, lat:5, rdata:32'h0BAD_F00D, exp_instr:1'b1};
        tbl[3] = '{side:1'b1, addr:32'hFFFF_FFFC, wdata:32'hA5A5_5A5A, wstrb:4'hF, fence:1'b1,
                   req_instr:1'b0, lat:4, rdata:32'h0000_0001, exp_instr:1'b0};
        vi = '{side:1'b0, addr:32'h0000_3000, wdata:32'h0, wstrb:4'h0, fence:1'b0,
               req_instr:1'b1, lat:2, rdata:32'h1111_1111, exp_instr:1'b1};
        vd = '{side:1'b1, addr:32'h4000_0000, wdata:32'h0, wstrb:4'h0, fence:1'b0,
               req_instr:1'b0, lat:3, rdata:32'h2222_2222, exp_instr:1'b0};
        vs = '{side:1'b1, addr:32'h8000_0010, wdata:32'h1234_5678, wstrb:4'h3, fence:1'b0,
               req_instr:1'b0, lat:4, rdata:32'h0, exp_instr:1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            txn($sformatf("vec%0d", i), tbl[i], 1, 1'b0, vi);
        end

        // Simultaneous requests from idle: dmem first, imem after one bubble.
        do_reset("rst2");
        for (int r = 0; r < 4; r++) begin
            drive_req(1'b0, vi);
            txn($sformatf("tie%0d_d", r), vd, 1, 1'b0, vi);
            txn($sformatf("tie%0d_i", r), vi, 1, 1'b0, vi);
        end

        // Both continuously valid.
`ifdef TIM_ARBITER_RR_EN
        exp_seq = '{vd, vi, vd, vi};
`else
        exp_seq = '{vd, vd, vd, vd};
`endif
        for (int r = 0; r < 4; r++) begin
            drive_req(1'b0, vi);
            drive_req(1'b1, vd);
            txn($sformatf("cont%0d", r), exp_seq[r], 1, 1'b0, vi);
        end
        imem_in = '0;
        dmem_in = '0;

        // dmem store with imem arriving mid-transaction.
        @(posedge clk);
        #1;
        txn("store", vs, 1, 1'b1, vi);
        txn("store_after_i", vi, 1, 1'b0, vi);

        // Reset during busy_d, then a late downstream ready.
        @(posedge clk);
        #1;
        drive_req(1'b1, vs);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (mem_in.mem_valid) got = 1'b1;
        end
        chk("rst_busy/issued", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        dmem_in = '0;
        #1;
        check_reset_vals("rst_busy/async");
        @(negedge clk);
        check_reset_vals("rst_busy/held");
        @(posedge clk);
        #1;
        rst               = 1'b1;
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        check_reset_vals("late_ready");
        @(posedge clk);
        #1;
        mem_out = '0;
        @(negedge clk);
        chk("late_ready/no_issue", 64'(mem_in.mem_valid), 64'd0);
        @(posedge clk);
        #1;
        txn("post_rst", vi, 1, 1'b0, vi);

        // Ready pulse while idle with no requests.
        @(posedge clk);
        #1;
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("idle_ready/iout", 64'(imem_out), 64'd0);
        chk("idle_ready/dout", 64'(dmem_out), 64'd0);
        @(posedge clk);
        #1;
        mem_out = '0;
        @(negedge clk);
        chk("idle_ready/no_issue", 64'(mem_in.mem_valid), 64'd0);
        @(posedge clk);
        #1;
        txn("post_idle", vd, 1, 1'b0, vi);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
